pong_score_ctrl: RTL and testbench
==================================

Name: pong_score_ctrl

Overview:
- Game-level score controller for the screen-pong pixel stream.
- Receives goal events from the ball/paddle logic and frame-end ticks from the stream.
- Sequences serve / play / point-hold / game-over, and owns both players' 1-digit scores.
- Drives the packed score byte consumed by the score overlay, which samples it at frame end.

Parameters:
- WIN_SCORE, 9: score (1..9) at which a player wins; saturates there.
- HOLD_FRAMES, 60: frames spent in POINT hold before re-serve (1..255).
- SERVE_FRAMES, 30: frames spent in SERVE before the ball is released (1..255).

Ports:
- px_clk  in  1  pixel clock; single clock domain.
- rst_n  in  1  asynchronous active-low reset.
- frame_end  in  1  one-cycle pulse at the last visible pixel of a frame.
- start  in  1  level/pulse request to start or restart a game.
- goal_l  in  1  one-cycle pulse: ball left through the left edge, so the right player scores.
- goal_r  in  1  one-cycle pulse: ball left through the right edge, so the left player scores.
- score  out  8  [7:4] left-player digit, [3:0] right-player digit (BCD 0..9).
- ball_en  out  1  high only in PLAY; ball logic moves the ball only when high.
- serve_req  out  1  one-cycle pulse on entry to SERVE; ball logic recentres the ball.
- game_over  out  1  high in GAMEOVER.
- winner  out  1  valid when game_over=1: 0 = left player won, 1 = right player won.
- score_blank  out  1  overlay blanking request (see Optional Feature).

Behaviour:
- Reset (async assert, sync release): state=IDLE, score=8'h00, ball_en=0, serve_req=0, game_over=0, winner=0, score_blank=0, frame counter=0.
- Registered outputs throughout; all state changes happen on px_clk rising edges.
- States and transitions:
  - IDLE: start=1 -> SERVE; scores cleared to 0 on this transition.
  - SERVE: serve_req pulses high in the first cycle. The counter counts frame_end pulses; after SERVE_FRAMES pulses -> PLAY and the counter clears.
  - PLAY: ball_en=1.
    - goal_r alone: left score +1.
    - goal_l alone: right score +1.
    - Either case -> POINT, or -> GAMEOVER if the new score equals WIN_SCORE.
    - goal_l and goal_r in the same cycle: no score change, -> SERVE (replay).
  - POINT: ball_en=0. Count HOLD_FRAMES frame_end pulses, then -> SERVE.
  - GAMEOVER: game_over=1; winner set on entry and held. start=1 -> SERVE with scores cleared and game_over cleared in the same edge.
- Goal pulses outside PLAY are ignored. This covers ball re-entry glitches during hold or serve.
- start is ignored in SERVE, PLAY and POINT.
- Score arithmetic is a 4-bit increment saturating at WIN_SCORE; a digit never exceeds 9.
- Score is updated on the clock edge after the goal pulse (1-cycle latency). The overlay samples it only at frame_end, so a mid-frame change never tears.
- frame_end coinciding with a state-entry edge: the pulse is not counted toward the new state's count.
- frame_end coinciding with the final count: the transition occurs on that edge.
- Frame counter is 8 bits; it clears on every state change and never wraps within a state.
- rst_n asserted mid-game returns immediately to IDLE with scores 0.

Optional Feature:
- Macro: SCORE_BLINK_EN.
- Defined:
  - In POINT, score_blank toggles every 8 frames (frame counter bit 3), starting low on entry.
  - The overlay suppresses digit ink while score_blank=1.
  - In GAMEOVER, score_blank toggles every 16 frames using a free-running 8-bit frame counter.
- Not defined: score_blank is tied to 0 and no blink logic is generated.

Decomposition:
- Shared package pong_pkg holds:
  - state encoding typedef (IDLE, SERVE, PLAY, POINT, GAMEOVER);
  - score field slices (left [7:4], right [3:0]);
  - the BCD digit width constant.
- One natural sub-module, pong_frame_timer: an 8-bit frame_end counter with clear, load target and done output. It is instantiated once and shared across SERVE and POINT.

Test Plan:
- Reset, then start pulse -> serve_req pulse one cycle later; after 30 frame_end pulses ball_en=1; score=8'h00.
- In PLAY, goal_r pulse -> next cycle score=8'h10, ball_en=0; after 60 frames serve_req pulses; after 30 more ball_en=1.
- Simultaneous goal_l and goal_r in PLAY -> score unchanged, state SERVE, serve_req pulse.
- Right player reaches 9 via goal_l pulses -> score=8'h09, game_over=1, winner=1. Further goals are ignored; start -> score=8'h00, game_over=0, serve_req pulse.
- Goal pulses during SERVE/POINT and start during PLAY -> no score or state change.
- rst_n low mid-POINT with score=8'h34 -> immediately score=8'h00, state IDLE, all outputs 0. With SCORE_BLINK_EN defined, score_blank toggles at POINT frames 8, 16, 24...

Source files
------------

// File: rtl/pong_pkg.sv
// Shared types and constants for the pong score controller.
// Holds the game-state encoding, the score byte field positions,
// the BCD digit width and a saturating digit-increment helper.
package pong_pkg;

    // One decimal digit per player.
    localparam int DIGIT_W = 4;

    // Field positions inside the packed score byte.
    localparam int SCORE_L_HI = 7;
    localparam int SCORE_L_LO = 4;
    localparam int SCORE_R_HI = 3;
    localparam int SCORE_R_LO = 0;

    // Game sequencing states.
    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SERVE    = 3'd1,
        ST_PLAY     = 3'd2,
        ST_POINT    = 3'd3,
        ST_GAMEOVER = 3'd4
    } pong_state_e;

    // Increment a digit, holding at the limit so it never passes it.
    function automatic logic [DIGIT_W-1:0] digit_sat_inc(
        input logic [DIGIT_W-1:0] d,
        input logic [DIGIT_W-1:0] lim
    );
        return (d >= lim) ? lim : d + 4'd1;
    endfunction

endpackage

// File: rtl/pong_score_ctrl_if.sv
// Signal bundle between the pixel stream / ball logic and the score
// controller. The controller attaches through the slave modport; the
// stream side (or a testbench) attaches through the master modport.
//
// Signalling: there is no back-pressure anywhere in this bundle. Every
// input is sampled on the rising px_clk edge; frame_end, goal_l and
// goal_r are single-cycle pulses, start may be a pulse or a level.
// All outputs are registered and change only on rising px_clk edges;
// serve_req is a single-cycle pulse, the rest are levels.
interface pong_score_ctrl_if;
    logic       frame_end;
    logic       start;
    logic       goal_l;
    logic       goal_r;
    logic [7:0] score;
    logic       ball_en;
    logic       serve_req;
    logic       game_over;
    logic       winner;
    logic       score_blank;

    modport master (
        output frame_end, start, goal_l, goal_r,
        input  score, ball_en, serve_req, game_over, winner, score_blank
    );

    modport slave (
        input  frame_end, start, goal_l, goal_r,
        output score, ball_en, serve_req, game_over, winner, score_blank
    );
endinterface

// File: rtl/pong_frame_timer.sv
// Counts frame_end pulses toward a target. A clear forces the count to
// zero and takes priority over a coincident pulse, so the pulse on a
// state-entry edge is not counted. done is asserted combinationally on
// the pulse that reaches the target, letting the owner change state on
// that same edge. The count saturates at 255 rather than wrapping.
// With SCORE_BLINK_EN defined, the next count value is exported so the
// blink logic can follow it.
module pong_frame_timer (
    input  logic       px_clk,
    input  logic       rst_n,
    input  logic       clr,
    input  logic       frame_end,
    input  logic [7:0] target,
    output logic       done
`ifdef SCORE_BLINK_EN
    ,
    output logic [7:0] count_nxt
`endif
);

    logic [7:0] cnt_q;
    logic [7:0] cnt_nxt;
    logic       cnt_inc;

    assign cnt_inc = frame_end && (cnt_q != 8'hFF);
    assign done    = frame_end && (({1'b0, cnt_q} + 9'd1) == {1'b0, target});

    // Next count: clear wins, otherwise step on a frame pulse.
    always_comb begin
        cnt_nxt = cnt_q;
        if (clr) begin
            cnt_nxt = 8'd0;
        end else if (cnt_inc) begin
            cnt_nxt = cnt_q + 8'd1;
        end
    end

    // Count register.
    always_ff @(posedge px_clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= 8'd0;
        end else begin
            cnt_q <= cnt_nxt;
        end
    end

`ifdef SCORE_BLINK_EN
    assign count_nxt = cnt_nxt;
`endif

endmodule

// File: rtl/pong_score_ctrl.sv
// Game-level score controller for the pong pixel stream.
// Sequences IDLE -> SERVE -> PLAY -> POINT/GAMEOVER, owns both one-digit
// scores and drives the packed score byte the overlay samples at frame end.
// Optional feature macro: SCORE_BLINK_EN (score blinking in POINT and
// GAMEOVER); without it score_blank is held low.
import pong_pkg::*;

module pong_score_ctrl #(
    parameter int WIN_SCORE    = 9,
    parameter int HOLD_FRAMES  = 60,
    parameter int SERVE_FRAMES = 30
) (
    input  logic              px_clk,
    input  logic              rst_n,
    pong_score_ctrl_if.slave  bus,
    output pong_state_e       state_dbg
);

    // A digit must never exceed 9, whatever the parameter says.
    localparam logic [DIGIT_W-1:0] WIN_D =
        (WIN_SCORE > 9) ? 4'd9 : 4'(WIN_SCORE);
    localparam logic [7:0] SERVE_T = 8'(SERVE_FRAMES);
    localparam logic [7:0] HOLD_T  = 8'(HOLD_FRAMES);

    pong_state_e        state_q;
    pong_state_e        state_nxt;
    logic [DIGIT_W-1:0] left_nxt;
    logic [DIGIT_W-1:0] right_nxt;
    logic [7:0]         score_q;
    logic               ball_en_q;
    logic               serve_req_q;
    logic               game_over_q;
    logic               winner_q;
    logic               winner_nxt;
    logic               tmr_clr;
    logic               tmr_done;
    logic [7:0]         tmr_target;

    // The timer restarts on every state change; SERVE and POINT share it.
    assign tmr_clr    = (state_nxt != state_q);
    assign tmr_target = (state_q == ST_SERVE) ? SERVE_T : HOLD_T;

`ifdef SCORE_BLINK_EN
    logic [7:0] tmr_count_nxt;
`endif

    pong_frame_timer u_timer (
        .px_clk    (px_clk),
        .rst_n     (rst_n),
        .clr       (tmr_clr),
        .frame_end (bus.frame_end),
        .target    (tmr_target),
        .done      (tmr_done)
`ifdef SCORE_BLINK_EN
        ,
        .count_nxt (tmr_count_nxt)
`endif
    );

    // Next state, next scores and winner latch.
    always_comb begin
        state_nxt  = state_q;
        left_nxt   = score_q[SCORE_L_HI:SCORE_L_LO];
        right_nxt  = score_q[SCORE_R_HI:SCORE_R_LO];
        winner_nxt = winner_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    state_nxt = ST_SERVE;
                    left_nxt  = '0;
                    right_nxt = '0;
                end
            end
            ST_SERVE: begin
                if (tmr_done) begin
                    state_nxt = ST_PLAY;
                end
            end
            ST_PLAY: begin
                if (bus.goal_l && bus.goal_r) begin
                    // Both edges at once: no point awarded, replay the serve.
                    state_nxt = ST_SERVE;
                end else if (bus.goal_r) begin
                    left_nxt = digit_sat_inc(score_q[SCORE_L_HI:SCORE_L_LO], WIN_D);
                    if (left_nxt == WIN_D) begin
                        state_nxt  = ST_GAMEOVER;
                        winner_nxt = 1'b0;
                    end else begin
                        state_nxt = ST_POINT;
                    end
                end else if (bus.goal_l) begin
                    right_nxt = digit_sat_inc(score_q[SCORE_R_HI:SCORE_R_LO], WIN_D);
                    if (right_nxt == WIN_D) begin
                        state_nxt  = ST_GAMEOVER;
                        winner_nxt = 1'b1;
                    end else begin
                        state_nxt = ST_POINT;
                    end
                end
            end
            ST_POINT: begin
                if (tmr_done) begin
                    state_nxt = ST_SERVE;
                end
            end
            ST_GAMEOVER: begin
                if (bus.start) begin
                    state_nxt = ST_SERVE;
                    left_nxt  = '0;
                    right_nxt = '0;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // State, score and registered output decode.
    always_ff @(posedge px_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            score_q     <= 8'h00;
            ball_en_q   <= 1'b0;
            serve_req_q <= 1'b0;
            game_over_q <= 1'b0;
            winner_q    <= 1'b0;
        end else begin
            state_q     <= state_nxt;
            score_q     <= {left_nxt, right_nxt};
            ball_en_q   <= (state_nxt == ST_PLAY);
            serve_req_q <= (state_nxt == ST_SERVE) && (state_q != ST_SERVE);
            game_over_q <= (state_nxt == ST_GAMEOVER);
            winner_q    <= winner_nxt;
        end
    end

`ifdef SCORE_BLINK_EN
    logic [7:0] free_q;
    logic [7:0] free_nxt;
    logic       blank_q;
    logic       blank_nxt;

    assign free_nxt = free_q + {7'd0, bus.frame_end};

    // Blink phase: every 8 held frames in POINT, every 16 frames in GAMEOVER.
    always_comb begin
        blank_nxt = 1'b0;
        if (state_nxt == ST_POINT) begin
            blank_nxt = tmr_count_nxt[3];
        end else if (state_nxt == ST_GAMEOVER) begin
            blank_nxt = free_nxt[4];
        end
    end

    // Free-running frame counter and blank register.
    always_ff @(posedge px_clk or negedge rst_n) begin
        if (!rst_n) begin
            free_q  <= 8'd0;
            blank_q <= 1'b0;
        end else begin
            free_q  <= free_nxt;
            blank_q <= blank_nxt;
        end
    end

    assign bus.score_blank = blank_q;
`else
    assign bus.score_blank = 1'b0;
`endif

    assign bus.score     = score_q;
    assign bus.ball_en   = ball_en_q;
    assign bus.serve_req = serve_req_q;
    assign bus.game_over = game_over_q;
    assign bus.winner    = winner_q;
    assign state_dbg     = state_q;

endmodule

// File: tb/tb_pong_score_ctrl.sv
// Self-checking bench for pong_score_ctrl with a behavioural game model.
module tb_pong_score_ctrl;
    import pong_pkg::*;

    localparam int WIN   = 9;
    localparam int HOLD  = 60;
    localparam int SERVE = 30;

    localparam int P_IDLE  = 0;
    localparam int P_SERVE = 1;
    localparam int P_PLAY  = 2;
    localparam int P_POINT = 3;
    localparam int P_OVER  = 4;

    logic        px_clk = 1'b0;
    logic        rst_n  = 1'b0;
    pong_state_e state_dbg;
    int          total  = 0;
    int          bad    = 0;

    // model of the game
    int m_phase, m_l, m_r, m_frames, m_free;
    bit m_serve, m_winner, m_blank;

    // clock / reset
    always #5 px_clk = ~px_clk;

    pong_score_ctrl_if bus();

    pong_score_ctrl #(
        .WIN_SCORE    (WIN),
        .HOLD_FRAMES  (HOLD),
        .SERVE_FRAMES (SERVE)
    ) dut (
        .px_clk    (px_clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .state_dbg (state_dbg)
    );

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic pong_state_e phase_state(input int p);
        case (p)
            P_SERVE: return ST_SERVE;
            P_PLAY:  return ST_PLAY;
            P_POINT: return ST_POINT;
            P_OVER:  return ST_GAMEOVER;
            default: return ST_IDLE;
        endcase
    endfunction

    task automatic model_reset();
        m_phase = P_IDLE; m_l = 0; m_r = 0; m_frames = 0; m_free = 0;
        m_serve = 0; m_winner = 0; m_blank = 0;
    endtask

    // One clock edge of the game rules.
    task automatic model_step(input bit fe, input bit st, input bit gl, input bit gr);
        int prev;
        prev = m_phase;
        if (fe) m_free = (m_free + 1) % 256;
        case (m_phase)
            P_IDLE: if (st) begin m_l = 0; m_r = 0; m_phase = P_SERVE; end
            P_SERVE: if (fe) begin
                m_frames++;
                if (m_frames == SERVE) m_phase = P_PLAY;
            end
            P_PLAY: begin
                if (gl && gr) begin
                    m_phase = P_SERVE;
                end else if (gr) begin
                    m_l = (m_l + 1 > WIN) ? WIN : m_l + 1;
                    if (m_l == WIN) begin m_phase = P_OVER; m_winner = 0; end
                    else m_phase = P_POINT;
                end else if (gl) begin
                    m_r = (m_r + 1 > WIN) ? WIN : m_r + 1;
                    if (m_r == WIN) begin m_phase = P_OVER; m_winner = 1; end
                    else m_phase = P_POINT;
                end
            end
            P_POINT: if (fe) begin
                m_frames++;
                if (m_frames == HOLD) m_phase = P_SERVE;
            end
            P_OVER: if (st) begin m_l = 0; m_r = 0; m_phase = P_SERVE; end
            default: ;
        endcase
        if (m_phase != prev) m_frames = 0;
        m_serve = (m_phase == P_SERVE) && (prev != P_SERVE);
        m_blank = 0;
`ifdef SCORE_BLINK_EN
        if (m_phase == P_POINT) m_blank = ((m_frames / 8) % 2) == 1;
        else if (m_phase == P_OVER) m_blank = ((m_free / 16) % 2) == 1;
`endif
    endtask

    // driver: one cycle of inputs, pulses dropped 2ns after the edge
    task automatic tick(input bit fe, input bit st, input bit gl, input bit gr);
        bus.frame_end = fe; bus.start = st; bus.goal_l = gl; bus.goal_r = gr;
        @(posedge px_clk);
        model_step(fe, st, gl, gr);
        #2;
        bus.frame_end = 0; bus.start = 0; bus.goal_l = 0; bus.goal_r = 0;
    endtask

    // n frame_end pulses with random idle gaps; ends right after the nth pulse edge
    task automatic run_frames(input int n);
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(0, 2)) tick(0, 0, 0, 0);
            tick(1, 0, 0, 0);
        end
    endtask

    task automatic wait_play();
        int n;
        n = 0;
        while (m_phase != P_PLAY && n < 1000) begin
            tick(1, 0, 0, 0);
            n++;
        end
        total++;
        if (bus.ball_en !== 1'b1 || m_phase != P_PLAY) begin
            bad++;
            $display("FAIL wait_play: ball_en=%b after %0d frames, want 1", bus.ball_en, n);
        end
    endtask

    task automatic test_reset();
        model_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge px_clk);
        #2;
        total++;
        if ({bus.score, bus.ball_en, bus.serve_req, bus.game_over, bus.winner, bus.score_blank} !== 13'h0) begin
            bad++;
            $display("FAIL reset_outputs: got score=%h be=%b sr=%b go=%b w=%b bl=%b want all 0",
                     bus.score, bus.ball_en, bus.serve_req, bus.game_over, bus.winner, bus.score_blank);
        end
        total++;
        if (state_dbg !== ST_IDLE) begin
            bad++; $display("FAIL reset_state: got %s want ST_IDLE", state_dbg.name());
        end
        rst_n = 1'b1;
        tick(1, 0, 1, 1);
        total++;
        if (state_dbg !== ST_IDLE || bus.score !== 8'h00) begin
            bad++; $display("FAIL idle_hold: got %s score=%h want ST_IDLE 00", state_dbg.name(), bus.score);
        end
    endtask

    task automatic test_serve();
        tick(0, 1, 0, 0);
        total++;
        if (bus.serve_req !== 1'b1 || state_dbg !== ST_SERVE || bus.score !== 8'h00) begin
            bad++;
            $display("FAIL serve_entry: got sr=%b %s score=%h want 1 ST_SERVE 00",
                     bus.serve_req, state_dbg.name(), bus.score);
        end
        tick(0, 1, 0, 0);
        total++;
        if (bus.serve_req !== 1'b0) begin
            bad++; $display("FAIL serve_pulse_width: got %b want 0", bus.serve_req);
        end
        run_frames(SERVE - 2);
        tick(1, 0, 0, 0);
        total++;
        if (bus.ball_en !== 1'b0 || state_dbg !== ST_SERVE) begin
            bad++; $display("FAIL serve_early: got be=%b %s want 0 ST_SERVE", bus.ball_en, state_dbg.name());
        end
        run_frames(1);
        total++;
        if (bus.ball_en !== 1'b1 || state_dbg !== ST_PLAY || bus.score !== 8'h00) begin
            bad++;
            $display("FAIL serve_release: got be=%b %s score=%h want 1 ST_PLAY 00",
                     bus.ball_en, state_dbg.name(), bus.score);
        end
    endtask

    task automatic test_goal_r();
        tick(0, 0, 0, 1);
        total++;
        if (bus.score !== 8'h10 || bus.ball_en !== 1'b0 || state_dbg !== ST_POINT) begin
            bad++;
            $display("FAIL goal_r: got score=%h be=%b %s want 10 0 ST_POINT", bus.score, bus.ball_en, state_dbg.name());
        end
        tick(0, 0, 1, 0); tick(0, 0, 0, 1); tick(0, 1, 0, 0); tick(1, 0, 1, 1);
        total++;
        if (bus.score !== 8'h10 || state_dbg !== ST_POINT) begin
            bad++; $display("FAIL point_ignore: got score=%h %s want 10 ST_POINT", bus.score, state_dbg.name());
        end
        run_frames(6);
        total++;
        if (bus.score_blank !== m_blank) begin
            bad++; $display("FAIL blank_f7: got %b want %b", bus.score_blank, m_blank);
        end
        run_frames(1);
        total++;
        if (bus.score_blank !== m_blank) begin
            bad++; $display("FAIL blank_f8: got %b want %b", bus.score_blank, m_blank);
        end
        run_frames(HOLD - 9);
        total++;
        if (bus.serve_req !== 1'b0 || state_dbg !== ST_POINT) begin
            bad++; $display("FAIL hold_early: got sr=%b %s want 0 ST_POINT", bus.serve_req, state_dbg.name());
        end
        run_frames(1);
        total++;
        if (bus.serve_req !== 1'b1 || state_dbg !== ST_SERVE) begin
            bad++; $display("FAIL hold_done: got sr=%b %s want 1 ST_SERVE", bus.serve_req, state_dbg.name());
        end
        tick(0, 0, 1, 0); tick(0, 0, 0, 1);
        total++;
        if (bus.score !== 8'h10 || state_dbg !== ST_SERVE) begin
            bad++; $display("FAIL serve_ignore: got score=%h %s want 10 ST_SERVE", bus.score, state_dbg.name());
        end
        run_frames(SERVE);
        total++;
        if (bus.ball_en !== 1'b1) begin
            bad++; $display("FAIL reserve: got be=%b want 1", bus.ball_en);
        end
    endtask

    task automatic test_double_goal();
        tick(0, 1, 0, 0);
        total++;
        if (state_dbg !== ST_PLAY || bus.serve_req !== 1'b0) begin
            bad++; $display("FAIL play_start: got %s sr=%b want ST_PLAY 0", state_dbg.name(), bus.serve_req);
        end
        tick(1, 0, 1, 1);
        total++;
        if (bus.score !== 8'h10 || state_dbg !== ST_SERVE || bus.serve_req !== 1'b1) begin
            bad++;
            $display("FAIL double_goal: got score=%h %s sr=%b want 10 ST_SERVE 1", bus.score, state_dbg.name(), bus.serve_req);
        end
        run_frames(SERVE - 1);
        total++;
        if (state_dbg !== ST_SERVE) begin
            bad++; $display("FAIL entry_frame: got %s want ST_SERVE", state_dbg.name());
        end
        run_frames(1);
        total++;
        if (state_dbg !== ST_PLAY) begin
            bad++; $display("FAIL entry_frame_done: got %s want ST_PLAY", state_dbg.name());
        end
    endtask

    task automatic test_random();
        logic [12:0] exp;
        for (int i = 0; i < 6000; i++) begin
            tick($urandom_range(0, 2) == 0, $urandom_range(0, 49) == 0,
                 $urandom_range(0, 29) == 0, $urandom_range(0, 29) == 0);
            exp = {4'(m_l), 4'(m_r), m_phase == P_PLAY, m_serve, m_phase == P_OVER, m_winner, m_blank};
            total++;
            if ({bus.score, bus.ball_en, bus.serve_req, bus.game_over, bus.winner, bus.score_blank} !== exp ||
                state_dbg !== phase_state(m_phase)) begin
                bad++;
                $display("FAIL random cyc %0d: got %h/%s want %h/%s", i,
                         {bus.score, bus.ball_en, bus.serve_req, bus.game_over, bus.winner, bus.score_blank},
                         state_dbg.name(), exp, phase_state(m_phase).name());
            end
        end
    endtask

    task automatic test_right_wins();
        rst_n = 1'b0;
        model_reset();
        @(posedge px_clk); #2;
        rst_n = 1'b1;
        tick(0, 1, 0, 0);
        for (int i = 0; i < WIN; i++) begin
            wait_play();
            tick(0, 0, 1, 0);
            total++;
            if (bus.score !== {4'h0, 4'(i + 1)}) begin
                bad++; $display("FAIL right_goal %0d: got %h want %h", i, bus.score, {4'h0, 4'(i + 1)});
            end
        end
        total++;
        if (bus.score !== 8'h09 || bus.game_over !== 1'b1 || bus.winner !== 1'b1 || state_dbg !== ST_GAMEOVER) begin
            bad++;
            $display("FAIL right_win: got score=%h go=%b w=%b %s want 09 1 1 ST_GAMEOVER",
                     bus.score, bus.game_over, bus.winner, state_dbg.name());
        end
        tick(0, 0, 1, 0); tick(0, 0, 0, 1); tick(1, 0, 1, 1);
        total++;
        if (bus.score !== 8'h09 || bus.game_over !== 1'b1) begin
            bad++; $display("FAIL over_ignore: got score=%h go=%b want 09 1", bus.score, bus.game_over);
        end
        tick(0, 1, 0, 0);
        total++;
        if (bus.score !== 8'h00 || bus.game_over !== 1'b0 || bus.serve_req !== 1'b1 || state_dbg !== ST_SERVE) begin
            bad++;
            $display("FAIL restart: got score=%h go=%b sr=%b %s want 00 0 1 ST_SERVE",
                     bus.score, bus.game_over, bus.serve_req, state_dbg.name());
        end
    endtask

    task automatic test_reset_mid_point();
        for (int i = 0; i < 7; i++) begin
            wait_play();
            if (i < 3) tick(0, 0, 0, 1);
            else tick(0, 0, 1, 0);
        end
        run_frames(5);
        total++;
        if (bus.score !== 8'h34 || state_dbg !== ST_POINT) begin
            bad++; $display("FAIL pre_reset: got score=%h %s want 34 ST_POINT", bus.score, state_dbg.name());
        end
        rst_n = 1'b0;
        model_reset();
        #1;
        total++;
        if ({bus.score, bus.ball_en, bus.serve_req, bus.game_over, bus.winner, bus.score_blank} !== 13'h0 ||
            state_dbg !== ST_IDLE) begin
            bad++;
            $display("FAIL async_reset: got score=%h be=%b sr=%b go=%b w=%b bl=%b %s want 0 ST_IDLE",
                     bus.score, bus.ball_en, bus.serve_req, bus.game_over, bus.winner, bus.score_blank,
                     state_dbg.name());
        end
        repeat (2) @(posedge px_clk);
        #2;
        rst_n = 1'b1;
        tick(1, 0, 1, 0);
        total++;
        if (state_dbg !== ST_IDLE || bus.score !== 8'h00) begin
            bad++; $display("FAIL post_reset: got %s score=%h want ST_IDLE 00", state_dbg.name(), bus.score);
        end
    endtask

    initial begin
        bus.frame_end = 0; bus.start = 0; bus.goal_l = 0; bus.goal_r = 0;
        test_reset();
        test_serve();
        test_goal_r();
        test_double_goal();
        test_random();
        test_right_wins();
        test_reset_mid_point();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
